// File: rtl/fifo_pkg.sv
// Shared FIFO package: read/write state codes, default widths, depth.
package fifo_pkg;
  localparam int FIFO_DEPTH     = 8;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int LEN_WIDTH_DEF  = 4;

  typedef enum logic [2:0] {
    RD_IDLE  = 3'b000,
    RD_REQ   = 3'b001,
    RD_WAIT  = 3'b010,
    RD_HOLD  = 3'b011,
    RD_DONE  = 3'b100,
    RD_ERROR = 3'b101
  } rd_state_e;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'b00,
    WR_WRITE = 2'b01,
    WR_FULL  = 2'b10
  } wr_state_e;
endpackage

// File: rtl/fifo_reader_ns.sv
// Burst reader next-state and strobe decoder (purely combinational).
module fifo_reader_ns
  import fifo_pkg::*;
(
  input  rd_state_e state,
  input  logic      start,
  input  logic      len_zero,
  input  logic      empty,
  input  logic      rd_ack,
  input  logic      rd_err,
  input  logic      m_ready,
  input  logic      last,
  output rd_state_e next_state,
  output logic      rd_en,
  output logic      load,
  output logic      dec,
  output logic      cap,
  output logic      clr
);
  always_comb begin
    next_state = RD_IDLE;
    rd_en      = 1'b0;
    load       = 1'b0;
    dec        = 1'b0;
    cap        = 1'b0;
    clr        = 1'b0;
    unique case (state)
      RD_IDLE: begin
        if (start && len_zero) begin
          next_state = RD_DONE;
        end else if (start) begin
          load       = 1'b1;
          next_state = RD_REQ;
        end
      end
      RD_REQ: begin
        rd_en      = !empty;
        next_state = empty ? RD_REQ : RD_WAIT;
      end
      RD_WAIT: begin
        if (rd_err) begin
          clr        = 1'b1;
          next_state = RD_ERROR;
        end else if (rd_ack) begin
          cap        = 1'b1;
          next_state = RD_HOLD;
        end else begin
          next_state = RD_WAIT;
        end
      end
      RD_HOLD: begin
        if (m_ready) begin
          dec        = 1'b1;
          next_state = last ? RD_DONE : RD_REQ;
        end else begin
          next_state = RD_HOLD;
        end
      end
      default: next_state = RD_IDLE;
    endcase
  end
endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side burst engine for the 8-entry FIFO.
// FIFO_READER_ERRCNT_EN adds the err_count/err_clr error counter.
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic                  empty,
  input  logic                  rd_ack,
  input  logic                  rd_err,
  input  logic [DATA_WIDTH-1:0] dout,
  output logic                  rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
`ifdef FIFO_READER_ERRCNT_EN
  input  logic                  err_clr,
  output logic [7:0]            err_count,
`endif
  output logic [LEN_WIDTH-1:0]  words_left
);
  rd_state_e             state_q, state_d;
  logic [LEN_WIDTH-1:0]  words_left_q, words_left_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  load, dec, cap, clr, last;

  assign last = (words_left_q == LEN_WIDTH'(1));

  fifo_reader_ns u_ns (
    .state      (state_q),
    .start      (start),
    .len_zero   (burst_len == '0),
    .empty      (empty),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err),
    .m_ready    (m_ready),
    .last       (last),
    .next_state (state_d),
    .rd_en      (rd_en),
    .load       (load),
    .dec        (dec),
    .cap        (cap),
    .clr        (clr)
  );

  always_comb begin
    words_left_d = words_left_q;
    m_data_d     = m_data_q;
    if (load)
      words_left_d = burst_len;
    else if (clr)
      words_left_d = '0;
    else if (dec && words_left_q != '0)
      words_left_d = words_left_q - 1'b1;
    if (cap)
      m_data_d = dout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RD_IDLE;
      words_left_q <= '0;
      m_data_q     <= '0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      m_data_q     <= m_data_d;
    end
  end

  assign m_valid    = (state_q == RD_HOLD);
  assign busy       = (state_q == RD_REQ) ||
                      (state_q == RD_WAIT) ||
                      (state_q == RD_HOLD);
  assign done       = (state_q == RD_DONE);
  assign err        = (state_q == RD_ERROR);
  assign m_data     = m_data_q;
  assign words_left = words_left_q;

`ifdef FIFO_READER_ERRCNT_EN
  logic [7:0] err_count_q, err_count_d;

  // clear wins over a same-cycle increment
  always_comb begin
    err_count_d = err_count_q;
    if (err_clr)
      err_count_d = '0;
    else if (clr && err_count_q != 8'hff)
      err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      err_count_q <= '0;
    else
      err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`endif
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: FIFO model, data scoreboard,
// table-driven bursts plus hand-written corner sequences.
module tb_fifo_burst_reader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  burst_len = '0;
  logic        empty;
  logic        rd_ack = 1'b0;
  logic        rd_err = 1'b0;
  logic [31:0] dout = '0;
  logic        rd_en, m_valid, busy, done, err;
  logic [31:0] m_data;
  logic        m_ready = 1'b1;
  logic [3:0]  words_left;
`ifdef FIFO_READER_ERRCNT_EN
  logic        err_clr = 1'b0;
  logic [7:0]  err_count;
`endif

  always #5 clk = ~clk;

  fifo_burst_reader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .burst_len  (burst_len),
    .empty      (empty),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err),
    .dout       (dout),
    .rd_en      (rd_en),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .busy       (busy),
    .done       (done),
    .err        (err),
`ifdef FIFO_READER_ERRCNT_EN
    .err_clr    (err_clr),
    .err_count  (err_count),
`endif
    .words_left (words_left)
  );

  // FIFO model: one-cycle read latency, rd_ack with dout
  logic [31:0] mem [64];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        flush_req = 1'b0;
  assign empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    rd_ack <= 1'b0;
    if (flush_req) begin
      rd_ptr <= wr_ptr;
    end else if (rd_en && wr_ptr != rd_ptr) begin
      dout   <= mem[rd_ptr % 64];
      rd_ack <= 1'b1;
      rd_ptr <= rd_ptr + 1;
    end
  end

  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int rd_cnt = 0;
  int done_cnt = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rd_en) rd_cnt++;
    if (done) done_cnt++;
    if (m_valid && m_ready && !reset) begin
      if (exp_q.size() == 0) chk("sb_unexpected", m_data, 32'hx);
      else chk("sb_data", m_data, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(logic [31:0] d);
    mem[wr_ptr % 64] = d;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(d);
  endtask

  task automatic flush();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 60 && !m_valid; i++) tick();
    chk("wait_valid", m_valid, 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 80 && !done; i++) tick();
    chk("wait_done", done, 1);
  endtask

  typedef struct {
    int          len;
    int          pre;
    logic [31:0] base;
    logic [31:0] step;
    int          lat;
  } vec_t;

  task automatic run_row(vec_t v);
    int fed, first;
    logic got;
    rd_cnt = 0;
    done_cnt = 0;
    fed = 0;
    for (int i = 0; i < v.pre; i++) begin
      push(v.base + i * v.step);
      fed++;
    end
    start = 1'b1;
    burst_len = 4'(v.len);
    tick();
    start = 1'b0;
    first = 0;
    got = 1'b0;
    for (int c = 1; c < 200; c++) begin
      if (m_valid && first == 0) first = c;
      if (done) begin
        got = 1'b1;
        break;
      end
      if (fed < v.len && (wr_ptr - rd_ptr) < 8) begin
        push(v.base + fed * v.step);
        fed++;
      end
      tick();
    end
    chk("row_done", got, 1);
    chk("row_latency", first, v.lat);
    tick();
    chk("row_rd_cnt", rd_cnt, v.len);
    chk("row_done_cnt", done_cnt, 1);
    chk("row_busy", busy, 0);
    chk("row_words_left", words_left, 0);
    chk("row_leftover", exp_q.size(), (v.pre > v.len) ? v.pre - v.len : 0);
    flush();
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{3, 8, 32'h11, 32'h11, 3};
    tbl[1] = '{1, 1, 32'hdead0001, 32'h1, 3};
    tbl[2] = '{15, 8, 32'h1000, 32'h101, 3};
    tbl[3] = '{0, 0, 32'h0, 32'h0, 0};
    tbl[4] = '{8, 4, 32'ha5a50000, 32'h7, 3};

    tick();
    tick();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_words_left", words_left, 0);
    chk("rst_m_data", m_data, 0);
`ifdef FIFO_READER_ERRCNT_EN
    chk("rst_err_count", err_count, 0);
`endif
    reset = 1'b0;
    tick();

    foreach (tbl[i]) run_row(tbl[i]);

    // empty FIFO stalls in REQ
    rd_cnt = 0;
    start = 1'b1;
    burst_len = 4'd2;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_busy", busy, 1);
      chk("stall_rd_en", rd_en, 0);
      tick();
    end
    push(32'hab);
    wait_valid();
    push(32'hcd);
    for (int i = 0; i < 80 && !done; i++) begin
      chk("stall_busy_run", busy, 1);
      tick();
    end
    chk("stall_done", done, 1);
    tick();
    chk("stall_rd_cnt", rd_cnt, 2);
    flush();

    // back-pressure holds data stable
    push(32'h5a5a5a5a);
    m_ready = 1'b0;
    start = 1'b1;
    burst_len = 4'd1;
    tick();
    start = 1'b0;
    wait_valid();
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", m_valid, 1);
      chk("bp_data", m_data, 32'h5a5a5a5a);
      chk("bp_words_left", words_left, 1);
      tick();
    end
    m_ready = 1'b1;
    tick();
    chk("bp_done", done, 1);
    chk("bp_words_left_end", words_left, 0);
    chk("bp_valid_end", m_valid, 0);
    tick();
    flush();

    // rd_err in WAIT wins over rd_ack
    for (int i = 0; i < 4; i++) push(32'h100 + i);
    start = 1'b1;
    burst_len = 4'd4;
    tick();
    start = 1'b0;
    chk("err_req_rd_en", rd_en, 1);
    rd_err = 1'b1;
    tick();
    chk("err_wait_ack", rd_ack, 1);
    tick();
    rd_err = 1'b0;
    chk("err_pulse", err, 1);
    chk("err_words_left", words_left, 0);
    chk("err_m_valid", m_valid, 0);
    chk("err_busy", busy, 0);
`ifdef FIFO_READER_ERRCNT_EN
    chk("err_count_inc", err_count, 1);
`endif
    tick();
    chk("err_pulse_end", err, 0);
    chk("err_idle_busy", busy, 0);
`ifdef FIFO_READER_ERRCNT_EN
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_count_clr", err_count, 0);
`endif
    flush();

    // reset while holding a word
    push(32'hc0ffee01);
    push(32'hc0ffee02);
    m_ready = 1'b0;
    start = 1'b1;
    burst_len = 4'd2;
    tick();
    start = 1'b0;
    wait_valid();
    reset = 1'b1;
    tick();
    chk("mrst_m_valid", m_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_words_left", words_left, 0);
    chk("mrst_m_data", m_data, 0);
    reset = 1'b0;
    m_ready = 1'b1;
    flush();
    run_row('{1, 1, 32'h77, 32'h1, 3});

    // start while busy is ignored
    rd_cnt = 0;
    start = 1'b1;
    burst_len = 4'd2;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    burst_len = 4'd9;
    tick();
    start = 1'b0;
    chk("busy_start_wl", words_left, 2);
    push(32'h901);
    push(32'h902);
    wait_done();
    tick();
    chk("busy_start_rd_cnt", rd_cnt, 2);
    chk("busy_start_leftover", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
